// File: rtl/i2c_seq_pkg.sv
// rtl/i2c_seq_pkg.sv - shared state type, length type and defaults for the I2C register-read sequencer
package i2c_seq_pkg;

  localparam int MAX_BYTES_DEF = 14;
  localparam int TIMEOUT_DEF   = 65535;

  typedef logic [3:0] len_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_PTR   = 3'd1,
    ST_RD_BYTES = 3'd2,
    ST_WAIT_END = 3'd3,
    ST_ABORT    = 3'd4,
    ST_FIN      = 3'd5
  } seq_state_t;

endpackage

// File: rtl/i2c_seq_edge.sv
// rtl/i2c_seq_edge.sv - rise/fall detector for the byte-level master busy flag
module i2c_seq_edge (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  output logic rise,
  output logic fall
);

  logic busy_q;

  always_ff @(posedge clk) begin
    if (reset) busy_q <= 1'b0;
    else       busy_q <= busy;
  end

  assign rise = busy & ~busy_q;
  assign fall = ~busy & busy_q;

endmodule

// File: rtl/i2c_reg_seq.sv
// rtl/i2c_reg_seq.sv - I2C burst register-read sequencer; watchdog enabled by I2C_REG_SEQ_TIMEOUT_EN
module i2c_reg_seq
  import i2c_seq_pkg::*;
#(
  parameter int MAX_BYTES      = MAX_BYTES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [3:0] len,
  output logic       seq_busy,
  output logic       done,
  output logic       err,
  output logic       rd_valid,
  output logic [3:0] rd_index,
  output logic [7:0] rd_data,
  output logic       m_ena,
  output logic [6:0] m_addr,
  output logic       m_rw,
  output logic [7:0] m_data_wr,
  input  logic       m_busy,
  input  logic [7:0] m_data_rd,
  input  logic       m_ack_error
);

  seq_state_t state;
  len_t       len_q;
  len_t       byte_cnt;
  logic [4:0] rise_cnt;
  logic [4:0] rise_num;
  logic [4:0] last_rise;
  logic       busy_rise;
  logic       busy_fall;
  logic       len_ok;
  logic       timed_out;
  logic       active;

  i2c_seq_edge u_edge (
    .clk   (clk),
    .reset (reset),
    .busy  (m_busy),
    .rise  (busy_rise),
    .fall  (busy_fall)
  );

  // rise 1 is the pointer write, rise 2 starts byte 0, rise 1+len starts the last byte
  assign rise_num  = rise_cnt + 5'd1;
  assign last_rise = {1'b0, len_q} + 5'd1;
  assign len_ok    = (len != 4'd0) && (int'(len) <= MAX_BYTES);
  assign active    = (state == ST_WR_PTR) || (state == ST_RD_BYTES) ||
                     (state == ST_WAIT_END) || (state == ST_ABORT);

`ifdef I2C_REG_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (reset || state == ST_IDLE || busy_rise || busy_fall) to_cnt <= '0;
    else if (!timed_out)                                     to_cnt <= to_cnt + TW'(1);
  end

  assign timed_out = (to_cnt == TW'(TIMEOUT_CYCLES));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timed_out      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      byte_cnt  <= '0;
      rise_cnt  <= '0;
      seq_busy  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rd_valid  <= 1'b0;
      rd_index  <= '0;
      rd_data   <= '0;
      m_ena     <= 1'b0;
      m_addr    <= '0;
      m_rw      <= 1'b0;
      m_data_wr <= '0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      if (state != ST_IDLE && busy_rise) rise_cnt <= rise_num;

      case (state)
        ST_IDLE: begin
          if (start) begin
            err      <= !len_ok;
            seq_busy <= 1'b1;
            rise_cnt <= '0;
            byte_cnt <= '0;
            rd_index <= '0;
            if (len_ok) begin
              len_q     <= len;
              m_addr    <= dev_addr;
              m_data_wr <= reg_addr;
              m_rw      <= 1'b0;
              m_ena     <= 1'b1;
              state     <= ST_WR_PTR;
            end else begin
              state <= ST_FIN;
            end
          end
        end
        ST_WR_PTR: begin
          if (m_ack_error) begin
            err   <= 1'b1;
            m_ena <= 1'b0;
            state <= ST_ABORT;
          end else if (busy_rise) begin
            m_rw  <= 1'b1;
            state <= ST_RD_BYTES;
          end
        end
        ST_RD_BYTES: begin
          if (m_ack_error) begin
            err   <= 1'b1;
            m_ena <= 1'b0;
            state <= ST_ABORT;
          end else if (busy_rise) begin
            if (rise_num >= 5'd3) begin
              rd_data  <= m_data_rd;
              rd_index <= byte_cnt;
              byte_cnt <= byte_cnt + 4'd1;
              rd_valid <= 1'b1;
            end
            if (rise_num == last_rise) begin
              m_ena <= 1'b0;
              state <= ST_WAIT_END;
            end
          end
        end
        ST_WAIT_END: begin
          if (m_ack_error) begin
            err   <= 1'b1;
            state <= ST_ABORT;
          end else if (busy_fall) begin
            rd_data  <= m_data_rd;
            rd_index <= byte_cnt;
            byte_cnt <= byte_cnt + 4'd1;
            rd_valid <= 1'b1;
            state    <= ST_FIN;
          end
        end
        ST_ABORT: begin
          if (!m_busy) state <= ST_FIN;
        end
        ST_FIN: begin
          done     <= 1'b1;
          seq_busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // watchdog bypasses the wait for m_busy so a hung master cannot stall the block
      if (timed_out && active) begin
        err   <= 1'b1;
        m_ena <= 1'b0;
        state <= ST_FIN;
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_seq.sv
// tb/tb_i2c_reg_seq.sv - self-checking bench for i2c_reg_seq with a byte-level master model
`timescale 1ns/1ps
module tb_i2c_reg_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr;
  logic [3:0] len;
  logic       seq_busy, done, err, rd_valid;
  logic [3:0] rd_index;
  logic [7:0] rd_data;
  logic       m_ena;
  logic [6:0] m_addr;
  logic       m_rw;
  logic [7:0] m_data_wr;
  logic       m_busy, m_ack_error;
  logic [7:0] m_data_rd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  i2c_reg_seq #(.MAX_BYTES(14), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .start(start), .dev_addr(dev_addr), .reg_addr(reg_addr),
    .len(len), .seq_busy(seq_busy), .done(done), .err(err), .rd_valid(rd_valid),
    .rd_index(rd_index), .rd_data(rd_data), .m_ena(m_ena), .m_addr(m_addr), .m_rw(m_rw),
    .m_data_wr(m_data_wr), .m_busy(m_busy), .m_data_rd(m_data_rd), .m_ack_error(m_ack_error)
  );

  localparam int BYTE_CYC = 8;

  // byte-level master model state
  bit         cfg_nack, cfg_stuck;
  logic [7:0] cfg_data [16];
  int         mst, mcnt, rd_no, nbytes;
  logic       lat_rw;
  logic [7:0] first_wr;
  logic [6:0] log_addr [$];
  logic       log_rw [$];

  initial begin
    m_busy = 0; m_ack_error = 0; m_data_rd = 0; mst = 0; mcnt = 0; rd_no = 0; nbytes = 0;
    lat_rw = 0; first_wr = 0; cfg_nack = 0; cfg_stuck = 0;
    forever begin
      @(posedge clk); #1;
      case (mst)
        0, 2: begin
          if (m_ena) begin
            m_busy = 1; mcnt = 0; lat_rw = m_rw;
            if (nbytes == 0) first_wr = m_data_wr;
            log_addr.push_back(m_addr);
            log_rw.push_back(m_rw);
            nbytes++;
            mst = 1;
          end else begin
            mst = 0;
          end
        end
        1: if (!cfg_stuck) begin
          mcnt++;
          if (mcnt == BYTE_CYC) begin
            if (nbytes == 1 && cfg_nack) begin
              m_ack_error = 1; mcnt = 0; mst = 3;
            end else begin
              if (lat_rw) begin m_data_rd = cfg_data[rd_no]; rd_no++; end
              m_busy = 0; mst = 2;
            end
          end
        end
        3: begin
          mcnt++;
          if (mcnt == 3) begin m_ack_error = 0; m_busy = 0; mst = 0; end
        end
        default: mst = 0;
      endcase
    end
  end

  // scoreboard and output monitor
  typedef struct packed {logic [3:0] idx; logic [7:0] data;} rd_exp_t;
  rd_exp_t sb_q [$];
  rd_exp_t me, pe;
  int  rd_cnt = 0, done_cnt = 0;
  bit  ena_seen = 0, ena_late = 0, prev_ack = 0;

  initial forever begin
    @(negedge clk);
    if (m_ena) ena_seen = 1;
    if (prev_ack && m_ena) ena_late = 1;
    prev_ack = m_ack_error;
    if (done) done_cnt++;
    if (rd_valid) begin
      rd_cnt++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL rd_extra: got index=%0d data=%02h, required no strobe", rd_index, rd_data);
      end else begin
        me = sb_q.pop_front();
        if (rd_index !== me.idx || rd_data !== me.data) begin
          failures++;
          $display("FAIL rd_byte: got index=%0d data=%02h, required index=%0d data=%02h",
                   rd_index, rd_data, me.idx, me.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic wait_model_idle();
    int n = 0;
    while ((mst != 0 || m_busy) && n < 500) begin @(negedge clk); n++; end
    chk("model_idle_wait", (mst == 0) ? 1 : 0, 1);
  endtask

  task automatic prep(input bit nack, input logic [7:0] base, input int nrd);
    wait_model_idle();
    cfg_nack = nack; cfg_stuck = 0; rd_no = 0; nbytes = 0;
    log_addr.delete(); log_rw.delete();
    for (int k = 0; k < 16; k++) cfg_data[k] = base + 8'(k);
    for (int k = 0; k < nrd; k++) begin
      pe.idx = 4'(k); pe.data = base + 8'(k);
      sb_q.push_back(pe);
    end
    rd_cnt = 0; ena_seen = 0; ena_late = 0;
  endtask

  task automatic do_start(input logic [6:0] d, input logic [7:0] r, input logic [3:0] l);
    @(negedge clk); dev_addr = d; reg_addr = r; len = l; start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 1;
    while (!done && cyc < budget) begin @(negedge clk); cyc++; end
    chk("done_seen", done, 1);
  endtask

  task automatic wait_rd(input int target);
    int n = 0;
    while (rd_cnt < target && n < 500) begin @(negedge clk); n++; end
    chk("rd_progress", (rd_cnt >= target) ? 1 : 0, 1);
  endtask

  function automatic bit rw_ok();
    if (log_rw.size() == 0 || log_rw[0] !== 1'b0) return 0;
    for (int k = 1; k < log_rw.size(); k++) if (log_rw[k] !== 1'b1) return 0;
    return 1;
  endfunction

  function automatic bit addr_ok(input logic [6:0] d);
    for (int k = 0; k < log_addr.size(); k++) if (log_addr[k] !== d) return 0;
    return 1;
  endfunction

  typedef struct {
    logic [6:0] dev;
    logic [7:0] reg_a;
    logic [3:0] len;
    bit         nack;
    logic [7:0] base;
    bit         exp_err;
    int         exp_nrd;
    bit         exp_bus;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  initial begin
    int cyc, d0;
    vecs[0] = '{7'h68, 8'h3B, 4'd6,  1'b0, 8'h01, 1'b0, 6,  1'b1};
    vecs[1] = '{7'h1E, 8'h10, 4'd1,  1'b0, 8'hA5, 1'b0, 1,  1'b1};
    vecs[2] = '{7'h58, 8'h22, 4'd4,  1'b1, 8'h00, 1'b1, 0,  1'b1};
    vecs[3] = '{7'h20, 8'h01, 4'd0,  1'b0, 8'h00, 1'b1, 0,  1'b0};
    vecs[4] = '{7'h21, 8'h02, 4'd15, 1'b0, 8'h00, 1'b1, 0,  1'b0};
    vecs[5] = '{7'h50, 8'h80, 4'd14, 1'b0, 8'hC0, 1'b0, 14, 1'b1};
    vecs[6] = '{7'h33, 8'h44, 4'd2,  1'b0, 8'h7E, 1'b0, 2,  1'b1};

    reset = 1; start = 0; dev_addr = 0; reg_addr = 0; len = 0;
    repeat (3) @(negedge clk);
    chk("rst_m_ena", m_ena, 0);
    chk("rst_m_rw", m_rw, 0);
    chk("rst_seq_busy", seq_busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_data_wr", m_data_wr, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_index", rd_index, 0);
    reset = 0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      prep(vecs[i].nack, vecs[i].base, vecs[i].exp_nrd);
      do_start(vecs[i].dev, vecs[i].reg_a, vecs[i].len);
      chk($sformatf("v%0d_seq_busy_rise", i), seq_busy, 1);
      wait_done(3000, cyc);
      chk($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      chk($sformatf("v%0d_seq_busy_at_done", i), seq_busy, 0);
      chk($sformatf("v%0d_rd_count", i), rd_cnt, vecs[i].exp_nrd);
      chk($sformatf("v%0d_sb_left", i), sb_q.size(), 0);
      @(negedge clk);
      chk($sformatf("v%0d_done_width", i), done, 0);
      if (vecs[i].exp_bus) begin
        chk($sformatf("v%0d_bytes", i), nbytes, vecs[i].nack ? 1 : 1 + int'(vecs[i].len));
        chk($sformatf("v%0d_rw_pattern", i), (vecs[i].nack || rw_ok()) ? 1 : 0, 1);
        chk($sformatf("v%0d_addr", i), addr_ok(vecs[i].dev), 1);
        chk($sformatf("v%0d_ptr_byte", i), first_wr, vecs[i].reg_a);
        if (vecs[i].nack) chk($sformatf("v%0d_ena_after_nack", i), ena_late, 0);
      end else begin
        chk($sformatf("v%0d_ena_seen", i), ena_seen, 0);
        chk($sformatf("v%0d_done_latency", i), (cyc <= 2) ? 1 : 0, 1);
      end
      sb_q.delete();
    end

    // start pulsed in the middle of a burst must not disturb it
    prep(1'b0, 8'h40, 6);
    do_start(7'h68, 8'h3B, 4'd6);
    wait_rd(2);
    @(negedge clk); dev_addr = 7'h11; reg_addr = 8'h00; len = 4'd3; start = 1;
    @(negedge clk); start = 0;
    d0 = done_cnt;
    wait_done(3000, cyc);
    chk("busy_start_rd_count", rd_cnt, 6);
    chk("busy_start_addr", addr_ok(7'h68), 1);
    chk("busy_start_bytes", nbytes, 7);
    chk("busy_start_err", err, 0);
    ena_seen = 0;
    repeat (30) @(negedge clk);
    chk("busy_start_single_done", done_cnt - d0, 1);
    chk("busy_start_no_restart", ena_seen, 0);
    sb_q.delete();

    // reset in the middle of a burst
    prep(1'b0, 8'h90, 6);
    do_start(7'h68, 8'h3B, 4'd6);
    wait_rd(2);
    @(negedge clk); reset = 1;
    @(negedge clk);
    chk("mid_rst_m_ena", m_ena, 0);
    chk("mid_rst_m_rw", m_rw, 0);
    chk("mid_rst_seq_busy", seq_busy, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_m_addr", m_addr, 0);
    chk("mid_rst_m_data_wr", m_data_wr, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    chk("mid_rst_rd_index", rd_index, 0);
    sb_q.delete();
    d0 = done_cnt;
    @(negedge clk); reset = 0;
    wait_model_idle();
    repeat (5) @(negedge clk);
    chk("mid_rst_no_done", done_cnt - d0, 0);
    chk("mid_rst_idle_busy", seq_busy, 0);

`ifdef I2C_REG_SEQ_TIMEOUT_EN
    // stuck master: watchdog ends the sequence 100 cycles after the last busy edge
    prep(1'b0, 8'h00, 0);
    cfg_stuck = 1;
    do_start(7'h2A, 8'h05, 4'd2);
    cyc = 0;
    while (!m_busy && cyc < 100) begin @(negedge clk); cyc++; end
    chk("to_busy_rise", m_busy, 1);
    wait_done(300, cyc);
    chk("to_cycles", (cyc >= 100 && cyc <= 105) ? 1 : 0, 1);
    chk("to_err", err, 1);
    chk("to_m_ena", m_ena, 0);
    chk("to_rd_count", rd_cnt, 0);
    cfg_stuck = 0;
    wait_model_idle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end

endmodule
